branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
Multi-cycle branch execution unit for the LEGv8 multicycle CPU, the parametrised successor to the single-shot branch control decode. The main control unit hands over a fetched branch instruction with a start/done handshake. The block then sequences EX0/EX1 itself, evaluates all 16 B.cond conditions plus CBZ/CBNZ, and drives the datapath control word, the K-mux select and the PC function.
It also keeps saturating taken/not-taken counters for branch statistics.

Parameters:
CW_W, 36, control word width; fixed field layout below, must be 36
LINK_REG, 28, destination register index written by BL
CNT_W, 16, width of each statistics counter
EN_BCOND, 1, 1 = B.cond supported; 0 = B.cond decodes as illegal

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  main CU hands over a branch; sampled only in IDLE
IR  in  32  instruction word, sampled with start
status  in  4  {V,C,N,Z} from status register
busy  out  1  high in EX0/EX1
done  out  1  one-cycle pulse, last cycle of the instruction
illegal  out  1  valid with done; instruction not a supported branch
taken  out  1  valid with done; PC was redirected
k_mux  out  3  immediate select: 010 imm26, 011 imm19, 000 none
controlWord  out  CW_W  {FS[5],SA[5],SB[5],DA[5],w_reg,C0,mem_cs[2],B_Sel,mem_write_en,IR_load,status_load,size[2],add_tri_sel,data_tri_sel[2],PC_sel,PC_FS[2]}
taken_cnt  out  CNT_W  count of taken branches
nt_cnt  out  CNT_W  count of not-taken branches

Behaviour:
- Reset state:
  - state = IDLE; ir_q, cond flags and both counters are 0.
  - All outputs are 0, except controlWord = idle word: PC_FS=00 (hold), PC_SEL=1, B_Sel=1, all enables 0.
- Decode on ir_q:
  - B: IR[31:26]=000101
  - BL: IR[31:26]=100101
  - BR: IR[31:21]=11010110000
  - CBZ: IR[31:24]=10110100
  - CBNZ: IR[31:24]=10110101
  - B.cond: IR[31:24]=01010100 with IR[4]=0
  - Anything else is illegal.
- PC_FS encoding: 00 hold, 01 PC+4, 10 load PC from register bus, 11 PC+sign-extended offset<<2.
- IDLE:
  - start=1 latches IR into ir_q and latches status into sflags, then goes to EX0.
  - start=0 stays in IDLE.
- EX0, busy=1, PC_FS=00 unless stated otherwise:
  - CBZ/CBNZ: FS=00100 (OR), SA=31, SB=IR[4:0], B_Sel=0, status_load=1.
  - BL: w_reg=1, DA=LINK_REG, data_tri_sel=11 (PC+4 source).
  - BR: SB=IR[9:5], PC_SEL=0, PC_FS=10, taken=1, done=1, next state IDLE.
  - Illegal: PC_FS=01, illegal=1, done=1, next state IDLE; counters unchanged.
  - All other classes go to EX1.
- EX1, busy=1, done=1, next state IDLE:
  - B/BL: PC_FS=11, taken=1.
  - CBZ: taken = status.Z (freshly loaded value).
  - CBNZ: taken = ~status.Z.
  - B.cond, cond=IR[3:0] evaluated on sflags:
    - EQ Z, NE ~Z
    - HS C, LO ~C
    - MI N, PL ~N
    - VS V, VC ~V
    - HI C&~Z, LS ~(C&~Z)
    - GE N==V, LT N!=V
    - GT ~Z&(N==V), LE ~GT
    - AL 1, NV 1
  - taken=1 gives PC_FS=11; taken=0 gives PC_FS=01.
- k_mux:
  - 011 for CB and B.cond.
  - 010 for B and BL.
  - 000 otherwise.
  - Driven from ir_q while busy; 000 in IDLE.
- Counters:
  - On done with illegal=0, exactly one of the two counters increments.
  - Each saturates at 2^CNT_W-1; no wrap.
- start while busy: ignored, no queueing.
- reset asserted mid-instruction: immediate return to IDLE; no done pulse.
- Latency: BR and illegal take 1 cycle after start, done in EX0. All other classes take 2 cycles, done in EX1.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding IDLE=0, EX0=1, EX1=2
  - PC_FS codes and k_mux codes
  - opcode match constants
  - control word field offsets
- One sub-module: branch_cond_eval (4-bit cond + {V,C,N,Z} -> take), purely combinational and reused by a future conditional-select unit.

Test Plan:
- reset, then B imm (IR=0x14000010), start pulse -> busy 2 cycles; EX0 PC_FS=00, k_mux=010; EX1 PC_FS=11, done=1, taken=1; taken_cnt=1.
- CBZ X3 (IR=0xB4000043) with status.Z=1 in EX1 -> EX0 status_load=1, SB=3, B_Sel=0; EX1 PC_FS=11, taken=1. Repeat with Z=0 -> PC_FS=01, nt_cnt=1.
- BR X30 (IR=0xD61F03C0) -> done in EX0 with PC_FS=10, SB=30, PC_SEL=0; back in IDLE next cycle.
- Sweep B.cond for cond 0..15 across all 16 status values -> taken matches the condition table. NV and AL are always taken. With EN_BCOND=0, every B.cond gives illegal=1.
- BL (IR=0x94000004) -> EX0 w_reg=1, DA=28, data_tri_sel=11; EX1 PC_FS=11. A start pulse issued in EX0 is ignored.
- reset in EX0 of CBNZ -> outputs return to the idle word at once, no done pulse; with CNT_W=2, five taken B -> taken_cnt saturates at 3.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions for the LEGv8 multicycle CPU.
// Holds the sequencer state encoding, PC function and K-mux codes,
// branch opcode match constants, control word field offsets and the
// branch class decode helper.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EX0  = 2'd1,
    ST_EX1  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILL,
    CLS_B,
    CLS_BL,
    CLS_BR,
    CLS_CBZ,
    CLS_CBNZ,
    CLS_BCOND
  } br_class_t;

  // PC function codes
  localparam logic [1:0] PC_FS_HOLD = 2'b00;
  localparam logic [1:0] PC_FS_INC  = 2'b01;
  localparam logic [1:0] PC_FS_REG  = 2'b10;
  localparam logic [1:0] PC_FS_OFS  = 2'b11;

  // K-mux immediate select codes
  localparam logic [2:0] K_NONE  = 3'b000;
  localparam logic [2:0] K_IMM26 = 3'b010;
  localparam logic [2:0] K_IMM19 = 3'b011;

  // Opcode match constants (compared against the top bits of IR)
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  // Control word field offsets (LSB of each field), 36-bit word
  localparam int CW_WIDTH        = 36;
  localparam int CW_FS_LSB       = 31;
  localparam int CW_SA_LSB       = 26;
  localparam int CW_SB_LSB       = 21;
  localparam int CW_DA_LSB       = 16;
  localparam int CW_W_REG        = 15;
  localparam int CW_C0           = 14;
  localparam int CW_MEM_CS_LSB   = 12;
  localparam int CW_B_SEL        = 11;
  localparam int CW_MEM_WE       = 10;
  localparam int CW_IR_LOAD      = 9;
  localparam int CW_STATUS_LOAD  = 8;
  localparam int CW_SIZE_LSB     = 6;
  localparam int CW_ADD_TRI      = 5;
  localparam int CW_DATA_TRI_LSB = 3;
  localparam int CW_PC_SEL       = 2;
  localparam int CW_PC_FS_LSB    = 0;

  // op = IR[31:21]; bit4 = IR[4] (must be 0 for B.cond).
  function automatic br_class_t decode_class(input logic [10:0] op,
                                             input logic        bit4,
                                             input logic        en_bcond);
    if (op[10:5] == OP_B)                           return CLS_B;
    if (op[10:5] == OP_BL)                          return CLS_BL;
    if (op == OP_BR)                                return CLS_BR;
    if (op[10:3] == OP_CBZ)                         return CLS_CBZ;
    if (op[10:3] == OP_CBNZ)                        return CLS_CBNZ;
    if (en_bcond && op[10:3] == OP_BCOND && !bit4)  return CLS_BCOND;
    return CLS_ILL;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational B.cond evaluator.
// Ports:
//   cond  - 4-bit condition code (EQ..NV)
//   flags - {V,C,N,Z}
//   take  - 1 when the condition holds
module branch_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       take
);

  logic v, c, n, z;
  assign v = flags[3];
  assign c = flags[2];
  assign n = flags[1];
  assign z = flags[0];

  always_comb begin
    take = 1'b0;
    unique case (cond)
      4'h0: take = z;
      4'h1: take = ~z;
      4'h2: take = c;
      4'h3: take = ~c;
      4'h4: take = n;
      4'h5: take = ~n;
      4'h6: take = v;
      4'h7: take = ~v;
      4'h8: take = c & ~z;
      4'h9: take = ~(c & ~z);
      4'hA: take = (n == v);
      4'hB: take = (n != v);
      4'hC: take = ~z & (n == v);
      4'hD: take = ~(~z & (n == v));
      4'hE: take = 1'b1;
      4'hF: take = 1'b1;  // NV behaves as always in LEGv8
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle branch execution unit. Accepts a branch from the main CU
// via start, sequences EX0/EX1, drives the datapath control word, K-mux
// select and PC function, and keeps saturating taken/not-taken counters.
// Ports:
//   clock, reset        - rising-edge clock, async active-high reset
//   start, IR, status   - handover from main CU (sampled in IDLE only)
//   busy                - high in EX0/EX1
//   done                - one-cycle pulse on the last cycle
//   illegal, taken      - valid with done
//   k_mux, controlWord  - datapath controls
//   taken_cnt, nt_cnt   - branch statistics
// Handshake: start is a request sampled only while busy=0; the
// instruction is complete on the cycle done=1, after which the unit is
// back in IDLE. start while busy is dropped, not queued.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_W     = 36,  // fixed field layout, must be 36
  parameter int LINK_REG = 28,
  parameter int CNT_W    = 16,
  parameter bit EN_BCOND = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      IR,
  input  logic [3:0]       status,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             taken,
  output logic [2:0]       k_mux,
  output logic [CW_W-1:0]  controlWord,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt
);

  // Idle word: PC held, PC_SEL=1, B_Sel=1, all enables low.
  localparam logic [CW_W-1:0] CW_IDLE = (CW_W'(1) << CW_PC_SEL) | (CW_W'(1) << CW_B_SEL);

  state_t    state_q, state_d;
  logic [31:0] ir_q;
  logic [3:0]  sflags;
  br_class_t   cls;
  logic        cond_take;
  logic        unused_ir;

  assign cls       = decode_class(ir_q[31:21], ir_q[4], EN_BCOND);
  assign unused_ir = ^ir_q[20:10];  // immediate bits go to the datapath, not here

  branch_cond_eval u_cond (
    .cond  (ir_q[3:0]),
    .flags (sflags),
    .take  (cond_take)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      sflags    <= '0;
      taken_cnt <= '0;
      nt_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        ir_q   <= IR;
        sflags <= status;
      end
      if (done && !illegal) begin
        if (taken) begin
          if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
        end else begin
          if (nt_cnt != '1) nt_cnt <= nt_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    taken       = 1'b0;
    k_mux       = K_NONE;
    controlWord = CW_IDLE;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_EX0;
      end

      ST_EX0: begin
        busy    = 1'b1;
        state_d = ST_EX1;
        unique case (cls)
          CLS_CBZ, CLS_CBNZ: begin
            // OR XZR with Rt so the status register captures Z of Rt
            controlWord[CW_FS_LSB +: 5] = 5'b00100;
            controlWord[CW_SA_LSB +: 5] = 5'd31;
            controlWord[CW_SB_LSB +: 5] = ir_q[4:0];
            controlWord[CW_B_SEL]       = 1'b0;
            controlWord[CW_STATUS_LOAD] = 1'b1;
          end
          CLS_BL: begin
            controlWord[CW_W_REG]             = 1'b1;
            controlWord[CW_DA_LSB +: 5]       = 5'(LINK_REG);
            controlWord[CW_DATA_TRI_LSB +: 2] = 2'b11;
          end
          CLS_BR: begin
            controlWord[CW_SB_LSB +: 5]    = ir_q[9:5];
            controlWord[CW_PC_SEL]         = 1'b0;
            controlWord[CW_PC_FS_LSB +: 2] = PC_FS_REG;
            taken   = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
          end
          CLS_ILL: begin
            controlWord[CW_PC_FS_LSB +: 2] = PC_FS_INC;
            illegal = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end

      ST_EX1: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
        unique case (cls)
          CLS_B, CLS_BL: taken = 1'b1;
          CLS_CBZ:       taken = status[0];   // Z written during EX0
          CLS_CBNZ:      taken = ~status[0];
          CLS_BCOND:     taken = cond_take;   // flags captured at start
          default:       taken = 1'b0;
        endcase
        controlWord[CW_PC_FS_LSB +: 2] = taken ? PC_FS_OFS : PC_FS_INC;
      end

      default: state_d = ST_IDLE;
    endcase

    if (busy) begin
      unique case (cls)
        CLS_B, CLS_BL:               k_mux = K_IMM26;
        CLS_CBZ, CLS_CBNZ, CLS_BCOND: k_mux = K_IMM19;
        default:                     k_mux = K_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: three instances share the stimulus
// (default, B.cond disabled, 2-bit counters).
module tb_branch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] IR = '0;
  logic [3:0]  status = '0;

  logic        m_busy, m_done, m_illegal, m_taken;
  logic [2:0]  m_k;
  logic [35:0] m_cw;
  logic [15:0] m_tc, m_nc;

  logic        n_busy, n_done, n_illegal, n_taken;
  logic [2:0]  n_k;
  logic [35:0] n_cw;
  logic [15:0] n_tc, n_nc;

  logic        s_busy, s_done, s_illegal, s_taken;
  logic [2:0]  s_k;
  logic [35:0] s_cw;
  logic [1:0]  s_tc, s_nc;

  int vectors = 0;
  int miscompares = 0;

  // model counters
  int tc_m = 0, nc_m = 0, tc_n = 0, nc_n = 0, tc_s = 0, nc_s = 0;

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  branch_sequencer u_main (
    .clock(clock), .reset(reset), .start(start), .IR(IR), .status(status),
    .busy(m_busy), .done(m_done), .illegal(m_illegal), .taken(m_taken),
    .k_mux(m_k), .controlWord(m_cw), .taken_cnt(m_tc), .nt_cnt(m_nc)
  );

  branch_sequencer #(.EN_BCOND(1'b0)) u_nob (
    .clock(clock), .reset(reset), .start(start), .IR(IR), .status(status),
    .busy(n_busy), .done(n_done), .illegal(n_illegal), .taken(n_taken),
    .k_mux(n_k), .controlWord(n_cw), .taken_cnt(n_tc), .nt_cnt(n_nc)
  );

  branch_sequencer #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .start(start), .IR(IR), .status(status),
    .busy(s_busy), .done(s_done), .illegal(s_illegal), .taken(s_taken),
    .k_mux(s_k), .controlWord(s_cw), .taken_cnt(s_tc), .nt_cnt(s_nc)
  );

  // reference model
  // 0 illegal, 1 B, 2 BL, 3 BR, 4 CBZ, 5 CBNZ, 6 B.cond
  function automatic int exp_cls(input logic [31:0] ir, input bit en_bcond);
    if (ir[31:26] == 6'b000101) return 1;
    if (ir[31:26] == 6'b100101) return 2;
    if (ir[31:21] == 11'b11010110000) return 3;
    if (ir[31:24] == 8'hB4) return 4;
    if (ir[31:24] == 8'hB5) return 5;
    if (en_bcond && ir[31:24] == 8'h54 && ir[4] == 1'b0) return 6;
    return 0;
  endfunction

  // Even codes are the base predicate, odd codes its inverse; 14/15 always.
  function automatic bit cond_model(input int c, input logic [3:0] f);
    bit v, cc, n, z, base;
    v = f[3]; cc = f[2]; n = f[1]; z = f[0];
    case (c / 2)
      0: base = z;
      1: base = cc;
      2: base = n;
      3: base = v;
      4: base = cc && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c >= 14) return 1'b1;
    return base ^ (c % 2 == 1);
  endfunction

  function automatic logic [35:0] make_cw(
    input logic [4:0] fs, input logic [4:0] sa, input logic [4:0] sb,
    input logic [4:0] da, input logic w_reg, input logic b_sel,
    input logic st_ld, input logic [1:0] dtri, input logic pc_sel,
    input logic [1:0] pc_fs);
    return {fs, sa, sb, da, w_reg, 1'b0, 2'b00, b_sel, 1'b0, 1'b0, st_ld,
            2'b00, 1'b0, dtri, pc_sel, pc_fs};
  endfunction

  function automatic int sat_inc(input int x, input int maxv);
    return (x < maxv) ? x + 1 : maxv;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_m_tc"}, 64'(m_tc), 64'(tc_m));
    chk({tag, "_m_nc"}, 64'(m_nc), 64'(nc_m));
    chk({tag, "_n_tc"}, 64'(n_tc), 64'(tc_n));
    chk({tag, "_n_nc"}, 64'(n_nc), 64'(nc_n));
    chk({tag, "_s_tc"}, 64'(s_tc), 64'(tc_s));
    chk({tag, "_s_nc"}, 64'(s_nc), 64'(nc_s));
  endtask

  // driver: one instruction from IDLE back to IDLE
  task automatic do_instr(input logic [31:0] ir, input logic [3:0] st0,
                          input logic [3:0] st1, input bit poke_start);
    int cm, cn;
    bit tk_m, tk_n, one_m, one_n;
    logic [2:0]  k;
    logic [35:0] cw0, cw1, idle_cw;

    idle_cw = make_cw(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00);
    cm = exp_cls(ir, 1'b1);
    cn = exp_cls(ir, 1'b0);
    one_m = (cm == 0 || cm == 3);
    one_n = (cn == 0 || cn == 3);
    k = (cm == 1 || cm == 2) ? 3'b010 : (cm >= 4) ? 3'b011 : 3'b000;
    cw0 = idle_cw;
    case (cm)
      0: cw0 = make_cw(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01);
      2: cw0 = make_cw(0, 0, 0, 5'd28, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00);
      3: cw0 = make_cw(0, 0, ir[9:5], 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10);
      4, 5: cw0 = make_cw(5'd4, 5'd31, ir[4:0], 0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00);
      default: ;
    endcase
    tk_m = (cm == 1 || cm == 2 || cm == 3) ? 1'b1 :
           (cm == 4) ? st1[0] : (cm == 5) ? !st1[0] :
           (cm == 6) ? cond_model(int'(ir[3:0]), st0) : 1'b0;
    tk_n = (cn == 6) ? 1'b0 : tk_m;
    if (cn == 0) tk_n = 1'b0;
    cw1 = make_cw(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, tk_m ? 2'b11 : 2'b01);

    @(posedge clock); #1;
    IR = ir; status = st0; start = 1'b1;
    @(negedge clock);
    chk("idle_busy", 64'(m_busy), 64'(0));
    chk("idle_cw", 64'(m_cw), 64'(idle_cw));

    @(posedge clock); #1;
    status = st1;
    if (poke_start) begin
      start = 1'b1;
      IR = 32'hD61F03C0;  // a BR that must be ignored
    end else begin
      start = 1'b0;
    end
    @(negedge clock);
    chk("ex0_busy", 64'(m_busy), 64'(1));
    chk("ex0_done", 64'(m_done), 64'(one_m));
    chk("ex0_illegal", 64'(m_illegal), 64'(cm == 0));
    chk("ex0_taken", 64'(m_taken), 64'(one_m && tk_m));
    chk("ex0_kmux", 64'(m_k), 64'(k));
    chk("ex0_cw", 64'(m_cw), 64'(cw0));
    chk("ex0_nob_done", 64'(n_done), 64'(one_n));
    chk("ex0_nob_illegal", 64'(n_illegal), 64'(cn == 0));

    @(posedge clock); #1;
    start = 1'b0;
    if (!one_m) begin
      @(negedge clock);
      chk("ex1_busy", 64'(m_busy), 64'(1));
      chk("ex1_done", 64'(m_done), 64'(1));
      chk("ex1_illegal", 64'(m_illegal), 64'(0));
      chk("ex1_taken", 64'(m_taken), 64'(tk_m));
      chk("ex1_kmux", 64'(m_k), 64'(k));
      chk("ex1_cw", 64'(m_cw), 64'(cw1));
      chk("ex1_nob_done", 64'(n_done), 64'(!one_n));
      chk("ex1_nob_taken", 64'(n_taken), 64'(!one_n && tk_n));
      @(posedge clock); #1;
    end

    if (cm != 0) begin
      if (tk_m) begin tc_m = sat_inc(tc_m, 65535); tc_s = sat_inc(tc_s, 3); end
      else      begin nc_m = sat_inc(nc_m, 65535); nc_s = sat_inc(nc_s, 3); end
    end
    if (cn != 0) begin
      if (tk_n) tc_n = sat_inc(tc_n, 65535);
      else      nc_n = sat_inc(nc_n, 65535);
    end

    @(negedge clock);
    chk("post_busy", 64'(m_busy), 64'(0));
    chk("post_done", 64'(m_done), 64'(0));
    chk_counters("post");
  endtask

  // reset asserted while the unit is in EX0
  task automatic do_reset_mid(input logic [31:0] ir);
    logic [35:0] idle_cw;
    idle_cw = make_cw(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b00);
    @(posedge clock); #1;
    IR = ir; status = 4'h0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("rst_pre_busy", 64'(m_busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    tc_m = 0; nc_m = 0; tc_n = 0; nc_n = 0; tc_s = 0; nc_s = 0;
    chk("rst_busy", 64'(m_busy), 64'(0));
    chk("rst_done", 64'(m_done), 64'(0));
    chk("rst_cw", 64'(m_cw), 64'(idle_cw));
    chk("rst_kmux", 64'(m_k), 64'(0));
    chk_counters("rst");
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_after_busy", 64'(m_busy), 64'(0));
    chk("rst_after_done", 64'(m_done), 64'(0));
  endtask

  // stimulus
  initial begin
    logic [31:0] ir;
    int pick;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", 64'(m_busy), 64'(0));
    chk("reset_done", 64'(m_done), 64'(0));
    chk("reset_illegal", 64'(m_illegal), 64'(0));
    chk("reset_taken", 64'(m_taken), 64'(0));
    chk("reset_kmux", 64'(m_k), 64'(0));
    chk("reset_cw", 64'(m_cw), 64'h000000804);
    chk_counters("reset");

    // directed
    do_instr(32'h14000010, 4'h0, 4'h0, 1'b0);  // B
    do_instr(32'hB4000043, 4'h0, 4'h1, 1'b0);  // CBZ, Z=1
    do_instr(32'hB4000043, 4'h1, 4'h0, 1'b0);  // CBZ, Z=0
    do_instr(32'hB5000043, 4'h0, 4'h0, 1'b0);  // CBNZ, Z=0
    do_instr(32'hD61F03C0, 4'h0, 4'h0, 1'b0);  // BR X30
    do_instr(32'h94000004, 4'h0, 4'h0, 1'b1);  // BL with start poked in EX0
    do_instr(32'h54000010, 4'h0, 4'h0, 1'b0);  // B.cond with IR[4]=1: illegal
    do_instr(32'hFFFFFFFF, 4'h0, 4'h0, 1'b0);  // illegal

    // B.cond sweep: every condition against every flag value
    for (int c = 0; c < 16; c++) begin
      for (int s = 0; s < 16; s++) begin
        ir = {8'h54, 19'($urandom), 1'b0, 4'(c)};
        do_instr(ir, 4'(s), 4'($urandom), 1'b0);
      end
    end

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0: ir = {6'b000101, 26'($urandom)};
        1: ir = {6'b100101, 26'($urandom)};
        2: ir = {11'b11010110000, 21'($urandom)};
        3: ir = {8'hB4, 24'($urandom)};
        4: ir = {8'hB5, 24'($urandom)};
        5: ir = {8'h54, 19'($urandom), 1'b0, 4'($urandom)};
        6: ir = {8'h54, 19'($urandom), 1'b1, 4'($urandom)};
        default: ir = $urandom;
      endcase
      do_instr(ir, 4'($urandom), 4'($urandom), 1'b0);
    end

    do_reset_mid(32'hB5000043);  // CBNZ interrupted in EX0

    // counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) do_instr(32'h14000010, 4'h0, 4'h0, 1'b0);
    chk("sat_taken_cnt", 64'(s_tc), 64'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0) $error("bench detected %0d miscompares", miscompares);
    $finish;
  end

endmodule
